// File: rtl/instr_sequencer.sv
// Fetch/decode/interrupt sequencer: owns the PC, fetches instructions and LDL literals,
// resolves NOP/RIT locally, issues everything else to execute, and takes vectored interrupts.
module instr_sequencer #(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 16,
  parameter int                IRQ_N      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [ADDR_W-1:0] VEC_BASE   = 'h0010,
  parameter int                VEC_STRIDE = 2,
  parameter bit                INT_EN_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ex_instr,
  output logic [DATA_W-1:0] ex_literal,
  output logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_done,
  input  logic              ex_branch,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ex_illegal,
  input  logic [IRQ_N-1:0]  irq,
  input  logic [IRQ_N-1:0]  irq_mask,
  output logic [IRQ_N-1:0]  irq_ack,
  output logic              int_en,
  output logic              halted
);

  localparam int KW = (IRQ_N > 1) ? $clog2(IRQ_N) : 1;
  localparam logic [15:0] W_NOP = 16'hFFFF;
  localparam logic [15:0] W_RIT = 16'hFFF7;
  localparam logic [11:0] W_LDL = 12'hFF1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_LIT,
    ST_ISSUE,
    ST_EXEC,
    ST_INT,
    ST_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] retaddr_q, retaddr_d;
  logic [ADDR_W-1:0] ex_pc_q, ex_pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] lit_q, lit_d;
  logic              int_en_q, int_en_d;
  logic [KW-1:0]     irq_k_q, irq_k_d;

  logic [IRQ_N-1:0]  pending;
  logic [KW-1:0]     pend_k;
  logic              take_irq;
  logic              boundary;
  logic [ADDR_W-1:0] npc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] vec_addr;
  logic [15:0]       word;

  assign word     = ir_q[15:0];
  assign pc_inc   = pc_q + ADDR_W'(1);
  assign vec_addr = VEC_BASE + ADDR_W'(irq_k_q) * ADDR_W'(VEC_STRIDE);

  // Lowest-numbered unmasked request wins; the index is latched at the boundary.
  always_comb begin
    pending = irq & ~irq_mask;
    pend_k  = '0;
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      if (pending[i]) pend_k = KW'(i);
    end
    take_irq = int_en_q && (pending != '0);
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retaddr_d = retaddr_q;
    ex_pc_d   = ex_pc_q;
    ir_d      = ir_q;
    lit_d     = lit_q;
    int_en_d  = int_en_q;
    irq_k_d   = irq_k_q;
    boundary  = 1'b0;
    npc       = pc_q;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          lit_d   = '0;
          ex_pc_d = pc_q;
          pc_d    = pc_inc;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (word == W_NOP) begin
          boundary = 1'b1;
        end else if (word == W_RIT) begin
          pc_d     = retaddr_q;
          int_en_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (word[15:4] == W_LDL) begin
          state_d = ST_LIT;
        end else begin
          state_d = ST_ISSUE;
        end
      end

      ST_LIT: begin
        if (imem_ack) begin
          lit_d   = imem_data;
          pc_d    = pc_inc;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (ex_ready) state_d = ST_EXEC;
      end

      // An illegal opcode stops the machine even if a branch is reported alongside it.
      ST_EXEC: begin
        if (ex_done) begin
          if (ex_illegal) begin
            state_d = ST_HALT;
          end else begin
            boundary = 1'b1;
            if (ex_branch) npc = ex_target;
          end
        end
      end

      // pc already holds the resume address, committed at the boundary.
      ST_INT: begin
        retaddr_d = pc_q;
        int_en_d  = 1'b0;
        pc_d      = vec_addr;
        state_d   = ST_FETCH;
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_IDLE;
    endcase

    if (boundary) begin
      pc_d    = npc;
      irq_k_d = pend_k;
      state_d = take_irq ? ST_INT : ST_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      retaddr_q <= '0;
      ex_pc_q   <= '0;
      ir_q      <= '0;
      lit_q     <= '0;
      int_en_q  <= INT_EN_RST;
      irq_k_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retaddr_q <= retaddr_d;
      ex_pc_q   <= ex_pc_d;
      ir_q      <= ir_d;
      lit_q     <= lit_d;
      int_en_q  <= int_en_d;
      irq_k_q   <= irq_k_d;
    end
  end

  assign imem_req   = (state_q == ST_FETCH) || (state_q == ST_LIT);
  assign imem_addr  = pc_q;
  assign ex_valid   = (state_q == ST_ISSUE);
  assign ex_instr   = ir_q;
  assign ex_literal = lit_q;
  assign ex_pc      = ex_pc_q;
  assign irq_ack    = (state_q == ST_INT) ? (IRQ_N'(1) << irq_k_q) : '0;
  assign int_en     = int_en_q;
  assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a behavioural instruction memory and execute unit
// record fetches, issues and acknowledges, and each test task compares them to its expectations.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = '0;
  logic        ex_valid;
  logic        ex_ready = 1'b0;
  logic [15:0] ex_instr;
  logic [15:0] ex_literal;
  logic [15:0] ex_pc;
  logic        ex_done = 1'b0;
  logic        ex_branch = 1'b0;
  logic [15:0] ex_target = '0;
  logic        ex_illegal = 1'b0;
  logic [3:0]  irq = '0;
  logic [3:0]  irq_mask;
  logic [3:0]  irq_ack;
  logic        int_en;
  logic        halted;

  instr_sequencer #(
    .DATA_W(16), .ADDR_W(16), .IRQ_N(4), .RESET_PC(16'h0000),
    .VEC_BASE(16'h0010), .VEC_STRIDE(2), .INT_EN_RST(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_instr(ex_instr), .ex_literal(ex_literal),
    .ex_pc(ex_pc), .ex_done(ex_done), .ex_branch(ex_branch), .ex_target(ex_target),
    .ex_illegal(ex_illegal), .irq(irq), .irq_mask(irq_mask), .irq_ack(irq_ack),
    .int_en(int_en), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] lit;
    logic [15:0] pc;
  } issue_t;

  typedef struct packed {
    logic [15:0] addr;
    logic        ien;
  } fetch_t;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] mem     [0:255];
  logic        br_tab  [0:255];
  logic [15:0] tgt_tab [0:255];
  logic        ill_tab [0:255];

  int          mem_wait = 0;
  int          ready_wait = 0;
  int          wait_cnt = 0;
  int          rdy_cnt = 0;
  logic        in_exec = 1'b0;
  logic [15:0] cur_pc = '0;
  logic [15:0] irq_pc = 16'hFFFF;
  logic [3:0]  irq_val = '0;

  issue_t     exp_issue_q[$];
  issue_t     obs_issue_q[$];
  fetch_t     exp_fetch_q[$];
  fetch_t     obs_fetch_q[$];
  logic [3:0] obs_ack_q[$];

  // Instruction memory: acknowledges after mem_wait idle request cycles and logs each fetch.
  always @(negedge clk) begin
    if (!rst_n || !imem_req) begin
      imem_ack  = 1'b0;
      imem_data = '0;
      wait_cnt  = 0;
    end else if (wait_cnt >= mem_wait) begin
      imem_ack  = 1'b1;
      imem_data = mem[imem_addr[7:0]];
      obs_fetch_q.push_back(fetch_t'{imem_addr, int_en});
      wait_cnt  = 0;
    end else begin
      imem_ack = 1'b0;
      wait_cnt++;
    end
  end

  // Execute unit: accepts after ready_wait offer cycles, completes the next cycle using the
  // per-address response tables, and raises irq for one cycle alongside done at irq_pc.
  always @(negedge clk) begin
    ex_done    = 1'b0;
    ex_branch  = 1'b0;
    ex_illegal = 1'b0;
    ex_target  = '0;
    irq        = '0;
    if (!rst_n) begin
      ex_ready = 1'b0;
      rdy_cnt  = 0;
      in_exec  = 1'b0;
    end else if (in_exec) begin
      ex_ready   = 1'b0;
      in_exec    = 1'b0;
      ex_done    = 1'b1;
      ex_branch  = br_tab[cur_pc[7:0]];
      ex_target  = tgt_tab[cur_pc[7:0]];
      ex_illegal = ill_tab[cur_pc[7:0]];
      if (cur_pc == irq_pc) irq = irq_val;
    end else if (ex_valid) begin
      if (rdy_cnt >= ready_wait) begin
        ex_ready = 1'b1;
        rdy_cnt  = 0;
        in_exec  = 1'b1;
        cur_pc   = ex_pc;
        obs_issue_q.push_back(issue_t'{ex_instr, ex_literal, ex_pc});
      end else begin
        ex_ready = 1'b0;
        rdy_cnt++;
      end
    end else begin
      ex_ready = 1'b0;
    end
    if (irq_ack != '0) obs_ack_q.push_back(irq_ack);
  end

  // Program image, execute responses and the expected fetch/issue streams for the main run.
  task automatic load_program();
    for (int a = 0; a < 256; a++) begin
      mem[a] = 16'hFFFF; br_tab[a] = 1'b0; tgt_tab[a] = '0; ill_tab[a] = 1'b0;
    end
    mem[0] = 16'h1123; mem[1] = 16'h2001; mem[2] = 16'hFFFF; mem[3] = 16'h3003;
    mem[4] = 16'hFF13; mem[5] = 16'hBEEF; mem[6] = 16'h4004; mem[7] = 16'h5005;
    mem[8] = 16'h6006; mem[8'h16] = 16'hFFF7; mem[8'h40] = 16'h7007;
    br_tab[8] = 1'b1;     tgt_tab[8] = 16'h0040;
    br_tab[8'h40] = 1'b1; tgt_tab[8'h40] = 16'h0080; ill_tab[8'h40] = 1'b1;
    irq_pc  = 16'h0007;
    irq_val = 4'b1010;
    exp_issue_q = '{issue_t'{16'h1123, 16'h0, 16'h0}, issue_t'{16'h2001, 16'h0, 16'h1},
                    issue_t'{16'h3003, 16'h0, 16'h3}, issue_t'{16'hFF13, 16'hBEEF, 16'h4},
                    issue_t'{16'h4004, 16'h0, 16'h6}, issue_t'{16'h5005, 16'h0, 16'h7},
                    issue_t'{16'h6006, 16'h0, 16'h8}, issue_t'{16'h7007, 16'h0, 16'h40}};
    exp_fetch_q = '{fetch_t'{16'h0, 1'b1}, fetch_t'{16'h1, 1'b1}, fetch_t'{16'h2, 1'b1},
                    fetch_t'{16'h3, 1'b1}, fetch_t'{16'h4, 1'b1}, fetch_t'{16'h5, 1'b1},
                    fetch_t'{16'h6, 1'b1}, fetch_t'{16'h7, 1'b1}, fetch_t'{16'h16, 1'b0},
                    fetch_t'{16'h8, 1'b1}, fetch_t'{16'h40, 1'b1}};
  endtask

  task automatic wait_obs(input int n_issue, input int n_fetch);
    for (int c = 0; c < 300; c++) begin
      if (obs_issue_q.size() >= n_issue && obs_fetch_q.size() >= n_fetch) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    issue_t e, o;
    fetch_t fe, fo;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b0 || imem_addr !== 16'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_imem: got req=%b addr=%h, expected req=0 addr=0000", imem_req, imem_addr);
    end
    tests_run++;
    if (ex_valid !== 1'b0 || ex_instr !== 16'h0 || ex_literal !== 16'h0 || ex_pc !== 16'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ex: got valid=%b instr=%h lit=%h pc=%h, expected all zero",
               ex_valid, ex_instr, ex_literal, ex_pc);
    end
    tests_run++;
    if (irq_ack !== 4'b0 || int_en !== 1'b1 || halted !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctl: got ack=%b int_en=%b halted=%b, expected ack=0000 int_en=1 halted=0",
               irq_ack, int_en, halted);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (ex_valid !== 1'(c == 3)) begin
        tests_failed++;
        $display("[TB] FAIL reset_latency cycle %0d: got ex_valid=%b, expected %b", c, ex_valid, c == 3);
      end
      if (c == 1) begin
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin
          tests_failed++;
          $display("[TB] FAIL first_fetch: got req=%b addr=%h, expected req=1 addr=0000", imem_req, imem_addr);
        end
      end
    end
    wait_obs(1, 2);
    tests_run++;
    e = exp_issue_q.pop_front();
    if (obs_issue_q.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_issue: got no issue, expected instr=%h pc=%h", e.instr, e.pc);
    end else begin
      o = obs_issue_q.pop_front();
      if (o !== e) begin
        tests_failed++;
        $display("[TB] FAIL reset_issue: got instr=%h lit=%h pc=%h, expected instr=%h lit=%h pc=%h",
                 o.instr, o.lit, o.pc, e.instr, e.lit, e.pc);
      end
    end
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      fe = exp_fetch_q.pop_front();
      if (obs_fetch_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL reset_fetch[%0d]: got no fetch, expected addr=%h", k, fe.addr);
      end else begin
        fo = obs_fetch_q.pop_front();
        if (fo !== fe) begin
          tests_failed++;
          $display("[TB] FAIL reset_fetch[%0d]: got addr=%h int_en=%b, expected addr=%h int_en=%b",
                   k, fo.addr, fo.ien, fe.addr, fe.ien);
        end
      end
    end
  endtask

  task automatic test_plain_nop();
    issue_t e, o;
    fetch_t fe, fo;
    wait_obs(2, 3);
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      e = exp_issue_q.pop_front();
      if (obs_issue_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL nop_issue[%0d]: got no issue, expected instr=%h pc=%h", k, e.instr, e.pc);
      end else begin
        o = obs_issue_q.pop_front();
        if (o !== e) begin
          tests_failed++;
          $display("[TB] FAIL nop_issue[%0d]: got instr=%h lit=%h pc=%h, expected instr=%h lit=%h pc=%h",
                   k, o.instr, o.lit, o.pc, e.instr, e.lit, e.pc);
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      fe = exp_fetch_q.pop_front();
      if (obs_fetch_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL nop_fetch[%0d]: got no fetch, expected addr=%h", k, fe.addr);
      end else begin
        fo = obs_fetch_q.pop_front();
        if (fo !== fe) begin
          tests_failed++;
          $display("[TB] FAIL nop_fetch[%0d]: got addr=%h int_en=%b, expected addr=%h int_en=%b",
                   k, fo.addr, fo.ien, fe.addr, fe.ien);
        end
      end
    end
  endtask

  task automatic test_ldl();
    issue_t e, o;
    fetch_t fe, fo;
    wait_obs(1, 2);
    tests_run++;
    e = exp_issue_q.pop_front();
    if (obs_issue_q.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL ldl_issue: got no issue, expected instr=%h lit=%h", e.instr, e.lit);
    end else begin
      o = obs_issue_q.pop_front();
      if (o !== e) begin
        tests_failed++;
        $display("[TB] FAIL ldl_issue: got instr=%h lit=%h pc=%h, expected instr=%h lit=%h pc=%h",
                 o.instr, o.lit, o.pc, e.instr, e.lit, e.pc);
      end
    end
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      fe = exp_fetch_q.pop_front();
      if (obs_fetch_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL ldl_fetch[%0d]: got no fetch, expected addr=%h", k, fe.addr);
      end else begin
        fo = obs_fetch_q.pop_front();
        if (fo !== fe) begin
          tests_failed++;
          $display("[TB] FAIL ldl_fetch[%0d]: got addr=%h int_en=%b, expected addr=%h int_en=%b",
                   k, fo.addr, fo.ien, fe.addr, fe.ien);
        end
      end
    end
  endtask

  task automatic test_interrupt();
    issue_t e, o;
    fetch_t fe, fo;
    logic [3:0] ack;
    wait_obs(3, 3);
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      e = exp_issue_q.pop_front();
      if (obs_issue_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL irq_issue[%0d]: got no issue, expected instr=%h pc=%h", k, e.instr, e.pc);
      end else begin
        o = obs_issue_q.pop_front();
        if (o !== e) begin
          tests_failed++;
          $display("[TB] FAIL irq_issue[%0d]: got instr=%h lit=%h pc=%h, expected instr=%h lit=%h pc=%h",
                   k, o.instr, o.lit, o.pc, e.instr, e.lit, e.pc);
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      fe = exp_fetch_q.pop_front();
      if (obs_fetch_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL irq_fetch[%0d]: got no fetch, expected addr=%h", k, fe.addr);
      end else begin
        fo = obs_fetch_q.pop_front();
        if (fo !== fe) begin
          tests_failed++;
          $display("[TB] FAIL irq_fetch[%0d]: got addr=%h int_en=%b, expected addr=%h int_en=%b",
                   k, fo.addr, fo.ien, fe.addr, fe.ien);
        end
      end
    end
    tests_run++;
    ack = (obs_ack_q.size() > 0) ? obs_ack_q[0] : 4'b0000;
    if (obs_ack_q.size() != 1 || ack !== 4'b1000) begin
      tests_failed++;
      $display("[TB] FAIL irq_ack: got %0d ack cycles first=%b, expected 1 cycle of 1000",
               obs_ack_q.size(), ack);
    end
    obs_ack_q.delete();
  endtask

  task automatic test_branch_halt();
    issue_t e, o;
    fetch_t fe, fo;
    logic ok;
    wait_obs(1, 1);
    tests_run++;
    e = exp_issue_q.pop_front();
    if (obs_issue_q.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL branch_issue: got no issue, expected instr=%h pc=%h", e.instr, e.pc);
    end else begin
      o = obs_issue_q.pop_front();
      if (o !== e) begin
        tests_failed++;
        $display("[TB] FAIL branch_issue: got instr=%h pc=%h, expected instr=%h pc=%h",
                 o.instr, o.pc, e.instr, e.pc);
      end
    end
    tests_run++;
    fe = exp_fetch_q.pop_front();
    if (obs_fetch_q.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL branch_fetch: got no fetch, expected addr=%h", fe.addr);
    end else begin
      fo = obs_fetch_q.pop_front();
      if (fo !== fe) begin
        tests_failed++;
        $display("[TB] FAIL branch_fetch: got addr=%h, expected addr=%h", fo.addr, fe.addr);
      end
    end
    for (int c = 0; c < 50 && halted !== 1'b1; c++) @(negedge clk);
    tests_run++;
    if (halted !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL halt_entry: got halted=%b, expected 1", halted);
    end
    ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (imem_req !== 1'b0 || ex_valid !== 1'b0 || halted !== 1'b1) ok = 1'b0;
    end
    tests_run++;
    if (!ok || obs_fetch_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL halt_hold: got stable=%b extra_fetches=%0d, expected stable=1 extra_fetches=0",
               ok, obs_fetch_q.size());
    end
  endtask

  task automatic test_stalls();
    int   req_cycles, val_cycles;
    logic addr_ok, ex_ok;
    issue_t o;
    fetch_t fo;
    #3 rst_n = 1'b0;
    #1;
    tests_run++;
    if (halted !== 1'b0 || imem_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL halt_reset: got halted=%b req=%b, expected halted=0 req=0", halted, imem_req);
    end
    obs_issue_q.delete(); obs_fetch_q.delete(); obs_ack_q.delete();
    mem_wait   = 3;
    ready_wait = 2;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20 && imem_req !== 1'b1; c++) @(negedge clk);
    req_cycles = 0;
    addr_ok = 1'b1;
    while (imem_req === 1'b1 && req_cycles < 20) begin
      if (imem_addr !== 16'h0) addr_ok = 1'b0;
      req_cycles++;
      @(negedge clk);
    end
    tests_run++;
    if (req_cycles != 4 || !addr_ok) begin
      tests_failed++;
      $display("[TB] FAIL stall_fetch: got %0d req cycles addr_stable=%b, expected 4 cycles stable",
               req_cycles, addr_ok);
    end
    for (int c = 0; c < 20 && ex_valid !== 1'b1; c++) @(negedge clk);
    val_cycles = 0;
    ex_ok = 1'b1;
    while (ex_valid === 1'b1 && val_cycles < 20) begin
      if (ex_instr !== 16'h1123 || ex_literal !== 16'h0 || ex_pc !== 16'h0) ex_ok = 1'b0;
      val_cycles++;
      @(negedge clk);
    end
    tests_run++;
    if (val_cycles != 3 || !ex_ok) begin
      tests_failed++;
      $display("[TB] FAIL stall_issue: got %0d valid cycles stable=%b, expected 3 cycles stable",
               val_cycles, ex_ok);
    end
    tests_run++;
    if (obs_issue_q.size() != 1 || obs_fetch_q.size() != 1) begin
      tests_failed++;
      $display("[TB] FAIL stall_counts: got issues=%0d fetches=%0d, expected 1 and 1",
               obs_issue_q.size(), obs_fetch_q.size());
    end else begin
      o  = obs_issue_q.pop_front();
      fo = obs_fetch_q.pop_front();
      tests_run++;
      if (o !== issue_t'{16'h1123, 16'h0, 16'h0} || fo.addr !== 16'h0) begin
        tests_failed++;
        $display("[TB] FAIL stall_content: got instr=%h pc=%h fetch=%h, expected instr=1123 pc=0000 fetch=0000",
                 o.instr, o.pc, fo.addr);
      end
    end
  endtask

  task automatic test_async_reset();
    issue_t o;
    fetch_t fo;
    for (int c = 0; c < 60 && !(ex_valid === 1'b1 && ex_pc === 16'h1); c++) @(negedge clk);
    tests_run++;
    if (ex_valid !== 1'b1 || ex_pc !== 16'h1) begin
      tests_failed++;
      $display("[TB] FAIL areset_reach_issue: got valid=%b pc=%h, expected valid=1 pc=0001", ex_valid, ex_pc);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (ex_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 16'h0 || ex_instr !== 16'h0 || ex_pc !== 16'h0) begin
      tests_failed++;
      $display("[TB] FAIL areset_clear: got valid=%b req=%b addr=%h instr=%h pc=%h, expected 0 0 0000 0000 0000",
               ex_valid, imem_req, imem_addr, ex_instr, ex_pc);
    end
    tests_run++;
    if (obs_issue_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL areset_no_issue: got %0d issues, expected 0", obs_issue_q.size());
    end
    obs_issue_q.delete(); obs_fetch_q.delete();
    mem_wait   = 0;
    ready_wait = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_obs(1, 1);
    tests_run++;
    if (obs_fetch_q.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL restart_fetch: got no fetch, expected addr=0000");
    end else begin
      fo = obs_fetch_q.pop_front();
      if (fo.addr !== 16'h0) begin
        tests_failed++;
        $display("[TB] FAIL restart_fetch: got addr=%h, expected addr=0000", fo.addr);
      end
    end
    tests_run++;
    if (obs_issue_q.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL restart_issue: got no issue, expected instr=1123 pc=0000");
    end else begin
      o = obs_issue_q.pop_front();
      if (o !== issue_t'{16'h1123, 16'h0, 16'h0}) begin
        tests_failed++;
        $display("[TB] FAIL restart_issue: got instr=%h lit=%h pc=%h, expected instr=1123 lit=0000 pc=0000",
                 o.instr, o.lit, o.pc);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    irq_mask = 4'b0010;
    load_program();
    test_reset();
    test_plain_nop();
    test_ldl();
    test_interrupt();
    test_branch_halt();
    test_stalls();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Parametrised fetch/decode/interrupt sequencer. It is the successor to the fixed 16-bit multi-cycle control unit. It fetches instruction words over a ready/ack instruction-memory handshake and fetches the literal word of LDL. It resolves NOP and RIT internally, issues every other instruction to the execute datapath over a valid/ready handshake, and takes vectored, prioritised interrupts at instruction boundaries. It sits between the instruction memory port and the execute/decode datapath, and owns the PC.

## Interface
- DATA_W, 16: instruction/literal width; must be ≥16.
- ADDR_W, 16: PC / instruction-address width.
- IRQ_N, 4: interrupt channels, 1..16.
- RESET_PC, 0: PC after reset.
- VEC_BASE, 'h0010: address of vector 0.
- VEC_STRIDE, 2: address distance between vectors.
- INT_EN_RST, 1: interrupt-enable value after reset.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  fetch address (current PC).
- imem_ack  in  1  fetch completes; imem_data valid this cycle.
- imem_data  in  DATA_W  fetched word.
- ex_valid  out  1  instruction offered to execute.
- ex_ready  in  1  execute accepts.
- ex_instr  out  DATA_W  instruction word.
- ex_literal  out  DATA_W  literal (LDL only, else 0).
- ex_pc  out  ADDR_W  address of the issued instruction.
- ex_done  in  1  execute finished the issued instruction (single-cycle pulse).
- ex_branch  in  1  with ex_done: branch taken.
- ex_target  in  ADDR_W  with ex_done: branch target.
- ex_illegal  in  1  with ex_done: undefined opcode.
- irq  in  IRQ_N  level interrupt requests.
- irq_mask  in  IRQ_N  1 = channel masked.
- irq_ack  out  IRQ_N  one-hot, one-cycle acknowledge.
- int_en  out  1  global interrupt enable.
- halted  out  1  sequencer stopped.

## Operation
- States: IDLE, FETCH, DECODE, LIT, ISSUE, EXEC, INT, HALT. Reset puts the sequencer in IDLE.
- IDLE: unconditional transition to FETCH.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ack: latch imem_data into ir, set pc←pc+1 (mod 2^ADDR_W), go to DECODE.
- DECODE, word W = ir[15:0]:
  - W=16'hFFFF (NOP): go to the boundary.
  - W=16'hFFF7 (RIT): pc←retaddr, int_en←1, go to IDLE. Interrupts are not checked on this boundary.
  - W[15:4]=12'hFF1 (LDL): go to LIT.
  - Otherwise: go to ISSUE.
- LIT: same handshake as FETCH. Latch the word into lit, set pc←pc+1, go to ISSUE.
- ISSUE: ex_valid=1 with ex_instr, ex_literal, ex_pc held stable. On ex_ready, go to EXEC.
- EXEC: wait for ex_done.
  - ex_illegal: go to HALT. This has priority over ex_branch.
  - Else ex_branch: npc=ex_target.
  - Else: npc=pc.
  - Then go to the boundary.
- Boundary: pending = irq & ~irq_mask, sampled this cycle.
  - If int_en and pending≠0: go to INT.
  - Otherwise: pc←npc, go to FETCH.
- INT (one cycle):
  - k = lowest set index of pending, as latched at the boundary.
  - retaddr←npc, int_en←0, pc←VEC_BASE+k·VEC_STRIDE (truncated to ADDR_W), irq_ack[k]=1.
  - Go to FETCH.
- HALT: all handshake outputs 0, halted=1. Only rst_n exits HALT.
- There is no nested interrupt entry while int_en=0. Interrupt entry never occurs mid-instruction.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, ex_valid 0, ex_instr 0, ex_literal 0, ex_pc 0, irq_ack 0, int_en INT_EN_RST, halted 0, retaddr 0.
- All outputs are registered or decoded directly from the state register. No combinational path from any input to any output.
- imem_ack may arrive in the first FETCH cycle; zero-wait instructions are fetched back-to-back. imem_req stays high until ack; imem_addr is stable while imem_req is high.
- Minimum instruction latency:
  - Plain instruction: FETCH 1, DECODE 1, ISSUE 1, EXEC 1 = 4 cycles. ex_done is sampled no earlier than the cycle after the accept.
  - LDL: +1 cycle.
  - NOP: 2 cycles.
  - Interrupt entry: +1 cycle.
- ex_done outside EXEC is ignored.
- An irq dropped before the boundary cycle is not taken. A channel masked at the boundary is not taken.
- Asserting rst_n low in any state, including mid-handshake, clears everything immediately to the reset values.
- PC wrap: 2^ADDR_W−1 increments to 0.

## Test plan
- Reset with RESET_PC=0, zero-wait memory holding 0x1123 at address 0 → imem_addr=0 and ex_valid the 3rd cycle after release with ex_instr=0x1123, ex_pc=0. After ex_done, next fetch at address 1.
- LDL: 0xFF13 at address 4, 0xBEEF at address 5 → ex_instr=0xFF13, ex_literal=0xBEEF; next fetch at address 6.
- Branch: ex_done with ex_branch=1, ex_target=0x0040 → next imem_addr=0x0040. Same cycle with ex_illegal=1 → halted=1, imem_req stays 0 until reset.
- Interrupts: irq=4'b1010, irq_mask=4'b0010, int_en=1 at the boundary of the instruction at address 7 → irq_ack=4'b1000, next fetch at 0x0016, int_en=0. A later RIT → fetch at address 8, int_en=1.
- Stalls: imem_ack delayed 3 cycles and ex_ready delayed 2 cycles → imem_addr and ex_* stable throughout, exactly one fetch and one issue.
- Async reset asserted during ISSUE with ex_valid=1 → ex_valid=0 immediately. Restart from RESET_PC.
